// File: rtl/dram_arb_pkg.sv
// Shared types and port identifiers for the two-master data RAM arbiter.
package dram_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/dram_rd_tag_pipe.sv
// Read-return tag delay line: tracks which port owns the RAM output RD_LAT cycles after issue.
module dram_rd_tag_pipe
    import dram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [RD_LAT-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU and an auxiliary master.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned AW     = 5,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          ram_ce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic    gnt0, gnt1;
    logic    last_gnt_q;
    rd_tag_t tag_in, tag_out;

    // Grants are forced low during reset so the RAM never sees an access while rst_n=0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (p0_req && p1_req) begin
                gnt0 = (last_gnt_q == PORT_AUX);
                gnt1 = (last_gnt_q == PORT_CPU);
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req;
            end
        end
    end

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    always_comb begin
        ram_ce = gnt0 | gnt1;
        if (gnt1) begin
            ram_wre = p1_we;
            ram_ad  = p1_addr;
            ram_din = p1_wdata;
        end else begin
            ram_wre = gnt0 & p0_we;
            ram_ad  = p0_addr;
            ram_din = p0_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= PORT_AUX;
        end else if (gnt0 || gnt1) begin
            last_gnt_q <= gnt1 ? PORT_AUX : PORT_CPU;
        end
    end

    always_comb begin
        tag_in.valid = ram_ce & ~ram_wre;
        tag_in.id    = gnt1 ? PORT_AUX : PORT_CPU;
    end

    dram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Read data is a straight passthrough of the RAM output; only the valids are steered.
    assign p0_rvalid = tag_out.valid && (tag_out.id == PORT_CPU);
    assign p1_rvalid = tag_out.valid && (tag_out.id == PORT_AUX);
    assign p0_rdata  = ram_dout;
    assign p1_rdata  = ram_dout;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench: RAM models behind two arbiter builds (RD_LAT=1 and RD_LAT=3).
module tb_dram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // RD_LAT=1 build
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [4:0]  p0_addr = 0, p1_addr = 0;
    logic [31:0] p0_wdata = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ram_ce, ram_wre;
    logic [4:0]  ram_ad;
    logic [31:0] ram_din, ram_dout;

    // RD_LAT=3 build
    logic        s_p0_req = 0, s_p0_we = 0, s_p1_req = 0, s_p1_we = 0;
    logic [4:0]  s_p0_addr = 0, s_p1_addr = 0;
    logic [31:0] s_p0_wdata = 0, s_p1_wdata = 0;
    logic        s_p0_gnt, s_p0_rvalid, s_p1_gnt, s_p1_rvalid;
    logic [31:0] s_p0_rdata, s_p1_rdata;
    logic        s_ram_ce, s_ram_wre;
    logic [4:0]  s_ram_ad;
    logic [31:0] s_ram_din, s_ram_dout;

    dram_port_arbiter #(.AW(5), .DW(32), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    dram_port_arbiter #(.AW(5), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(s_p0_req), .p0_we(s_p0_we), .p0_addr(s_p0_addr), .p0_wdata(s_p0_wdata),
        .p0_gnt(s_p0_gnt), .p0_rvalid(s_p0_rvalid), .p0_rdata(s_p0_rdata),
        .p1_req(s_p1_req), .p1_we(s_p1_we), .p1_addr(s_p1_addr), .p1_wdata(s_p1_wdata),
        .p1_gnt(s_p1_gnt), .p1_rvalid(s_p1_rvalid), .p1_rdata(s_p1_rdata),
        .ram_ce(s_ram_ce), .ram_wre(s_ram_wre), .ram_ad(s_ram_ad), .ram_din(s_ram_din),
        .ram_dout(s_ram_dout)
    );

    // RAM models: registered output, plus two extra output stages for the RD_LAT=3 build
    logic [31:0] mem1 [32];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem1[ram_ad] <= ram_din;
            else         ram_dout <= mem1[ram_ad];
        end
    end

    logic [31:0] mem3 [32];
    logic [31:0] s_dpipe [3];
    always @(posedge clk) begin
        if (s_ram_ce && s_ram_wre) mem3[s_ram_ad] <= s_ram_din;
        if (s_ram_ce && !s_ram_wre) s_dpipe[0] <= mem3[s_ram_ad];
        s_dpipe[1] <= s_dpipe[0];
        s_dpipe[2] <= s_dpipe[1];
    end
    assign s_ram_dout = s_dpipe[2];

    // Reference model for the RD_LAT=1 build
    typedef struct {
        bit          v;
        bit          id;
        logic [31:0] d;
    } ret_t;

    bit          m_last = 1'b1;
    logic [31:0] m_mem [32];
    ret_t        m_cur = '{v: 1'b0, id: 1'b0, d: '0};
    int          checks = 0;
    int          errors = 0;

    // {p1,p0} grant: lone requester wins, a tie goes to whoever did not win last
    function automatic logic [1:0] m_arb(input logic r0, input logic r1, input bit last);
        if (r0 && r1) return last ? 2'b01 : 2'b10;
        return {r1, r0};
    endfunction

    task automatic model_reset();
        m_last = 1'b1;
        m_cur  = '{v: 1'b0, id: 1'b0, d: '0};
    endtask

    // Advance one clock, applying this cycle's granted access to the model
    task automatic tick();
        logic [1:0] g;
        ret_t       e;
        g = m_arb(p0_req, p1_req, m_last);
        e = '{v: 1'b0, id: 1'b0, d: '0};
        if (g[0]) begin
            if (p0_we) m_mem[p0_addr] = p0_wdata;
            else       e = '{v: 1'b1, id: 1'b0, d: m_mem[p0_addr]};
            m_last = 1'b0;
        end else if (g[1]) begin
            if (p1_we) m_mem[p1_addr] = p1_wdata;
            else       e = '{v: 1'b1, id: 1'b1, d: m_mem[p1_addr]};
            m_last = 1'b1;
        end
        @(posedge clk);
        #1;
        m_cur = e;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        p0_req = 0; p1_req = 0; s_p0_req = 0; s_p1_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        p0_req = 1; p0_we = 1; p0_addr = 5'd0; p0_wdata = 32'h0BAD_0000;
        p1_req = 1; p1_we = 1; p1_addr = 5'd1; p1_wdata = 32'h0BAD_0001;
        s_p0_req = 1; s_p1_req = 1;
        @(negedge clk);
        checks++;
        if ({p1_gnt, p0_gnt, ram_ce, ram_wre} !== 4'b0) begin
            errors++;
            $display("FAIL reset_gnt_ce: got %b want 0000", {p1_gnt, p0_gnt, ram_ce, ram_wre});
        end
        checks++;
        if ({p1_rvalid, p0_rvalid, s_p1_rvalid, s_p0_rvalid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_rvalid: got %b want 0000",
                     {p1_rvalid, p0_rvalid, s_p1_rvalid, s_p0_rvalid});
        end
        checks++;
        if ({s_p1_gnt, s_p0_gnt, s_ram_ce} !== 3'b0) begin
            errors++;
            $display("FAIL reset_gnt_lat3: got %b want 000", {s_p1_gnt, s_p0_gnt, s_ram_ce});
        end
        s_p0_req = 0; s_p1_req = 0;
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_tie: got %b want 01", {p1_gnt, p0_gnt});
        end
        checks++;
        if ({ram_ce, ram_wre, ram_ad, ram_din} !== {1'b1, 1'b1, 5'd0, 32'h0BAD_0000}) begin
            errors++;
            $display("FAIL reset_ram_drive: got ce=%b we=%b ad=%0d din=%h want 1 1 0 0bad0000",
                     ram_ce, ram_wre, ram_ad, ram_din);
        end
        tick();
        p0_req = 0;
        @(negedge clk);
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL reset_p1_next: got %b want 10", {p1_gnt, p0_gnt});
        end
        tick();
        p1_req = 0;
    endtask

    task automatic test_fill();
        for (int a = 0; a < 32; a++) begin
            p1_req = 1; p1_we = 1; p1_addr = 5'(a); p1_wdata = $urandom;
            @(negedge clk);
            checks++;
            if ({p1_gnt, ram_wre, ram_ad, ram_din} !== {1'b1, 1'b1, p1_addr, p1_wdata}) begin
                errors++;
                $display("FAIL fill addr %0d: got gnt=%b we=%b ad=%0d din=%h", a, p1_gnt,
                         ram_wre, ram_ad, ram_din);
            end
            tick();
        end
        p1_req = 0;
    endtask

    task automatic test_single_read();
        p0_req = 1; p0_we = 1; p0_addr = 5'd5; p0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tick();
        p0_we = 0;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, ram_ce, ram_wre, ram_ad} !== {4'b1010, 5'd5}) begin
            errors++;
            $display("FAIL read5_issue: got gnt0=%b gnt1=%b ce=%b we=%b ad=%0d", p0_gnt,
                     p1_gnt, ram_ce, ram_wre, ram_ad);
        end
        tick();
        p0_req = 0;
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read5_return: got rv0=%b rv1=%b data=%h want 1 0 deadbeef",
                     p0_rvalid, p1_rvalid, p0_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL read5_pulse: got %b want 00", {p0_rvalid, p1_rvalid});
        end
    endtask

    task automatic test_write_then_read();
        p1_req = 1; p1_we = 1; p1_addr = 5'd31; p1_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (p1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wr31_gnt: got %b want 1", p1_gnt);
        end
        tick();
        p1_req = 0;
        p0_req = 1; p0_we = 0; p0_addr = 5'd31;
        @(negedge clk);
        tick();
        p0_req = 0;
        @(negedge clk);
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd31_after_wr: got rv=%b data=%h want 1 12345678", p0_rvalid,
                     p0_rdata);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old7;
        old7 = m_mem[7];
        p1_req = 1; p1_we = 0; p1_addr = 5'd7;
        @(negedge clk);
        tick();
        p0_req = 1; p0_we = 1; p0_addr = 5'd3; p0_wdata = 32'hA5A5_0003;
        p1_addr = 5'd3;
        @(negedge clk);
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL collide_p0_wins: got %b want 01", {p1_gnt, p0_gnt});
        end
        checks++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== old7) begin
            errors++;
            $display("FAIL collide_rv_with_gnt: got rv=%b data=%h want 1 %h", p1_rvalid,
                     p1_rdata, old7);
        end
        tick();
        p0_req = 0;
        @(negedge clk);
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL collide_p1_next: got %b want 10", {p1_gnt, p0_gnt});
        end
        tick();
        p1_req = 0;
        @(negedge clk);
        checks++;
        if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0 || p1_rdata !== 32'hA5A5_0003) begin
            errors++;
            $display("FAIL collide_new_data: got rv1=%b rv0=%b data=%h want 1 0 a5a50003",
                     p1_rvalid, p0_rvalid, p1_rdata);
        end
        tick();
    endtask

    task automatic test_alternate();
        logic [1:0] g;
        apply_reset();
        p0_req = 1; p0_we = 0; p0_addr = 5'($urandom_range(0, 31));
        p1_req = 1; p1_we = 0; p1_addr = 5'($urandom_range(0, 31));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({p1_gnt, p0_gnt} !== g) begin
                errors++;
                $display("FAIL alt_gnt cycle %0d: got %b want %b", i, {p1_gnt, p0_gnt}, g);
            end
            checks++;
            if ({p1_rvalid, p0_rvalid} !== {m_cur.v && m_cur.id, m_cur.v && !m_cur.id}) begin
                errors++;
                $display("FAIL alt_rvalid cycle %0d: got %b want v=%b id=%b", i,
                         {p1_rvalid, p0_rvalid}, m_cur.v, m_cur.id);
            end
            if (m_cur.v) begin
                checks++;
                if ((m_cur.id ? p1_rdata : p0_rdata) !== m_cur.d) begin
                    errors++;
                    $display("FAIL alt_rdata cycle %0d: got %h want %h", i,
                             m_cur.id ? p1_rdata : p0_rdata, m_cur.d);
                end
            end
            tick();
            if (g[0]) p0_addr = 5'($urandom_range(0, 31));
            else      p1_addr = 5'($urandom_range(0, 31));
        end
        p0_req = 0; p1_req = 0;
        tick();
    endtask

    task automatic test_reset_midflight();
        p0_req = 1; p0_we = 0; p0_addr = 5'd9;
        s_p0_req = 1; s_p0_we = 0; s_p0_addr = 5'd9;
        @(negedge clk);
        checks++;
        if ({p0_gnt, s_p0_gnt} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_issue: got %b want 11", {p0_gnt, s_p0_gnt});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        p0_req = 0; s_p0_req = 0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({p1_rvalid, p0_rvalid, s_p1_rvalid, s_p0_rvalid} !== 4'b0) begin
                errors++;
                $display("FAIL midrst_no_rvalid cycle %0d: got %b want 0000", i,
                         {p1_rvalid, p0_rvalid, s_p1_rvalid, s_p0_rvalid});
            end
            if (i == 1) rst_n = 1'b1;
        end
        p0_req = 1; p0_we = 0; p0_addr = 5'd2;
        p1_req = 1; p1_we = 0; p1_addr = 5'd4;
        #1;
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_tie: got %b want 01", {p1_gnt, p0_gnt});
        end
        tick();
        p0_req = 0;
        tick();
        p1_req = 0;
        tick();
    endtask

    task automatic test_lat3();
        logic [31:0] vals [4];
        logic        exp_v;
        for (int n = 0; n < 4; n++) vals[n] = $urandom;
        for (int n = 0; n < 4; n++) begin
            s_p1_req = 1; s_p1_we = 1; s_p1_addr = 5'(n); s_p1_wdata = vals[n];
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        s_p1_we = 0;
        for (int n = 0; n < 10; n++) begin
            if (n < 4) begin
                s_p1_req = 1; s_p1_addr = 5'(n);
            end else begin
                s_p1_req = 0;
            end
            @(negedge clk);
            exp_v = (n >= 3 && n <= 6);
            checks++;
            if ({s_p0_rvalid, s_p1_rvalid, s_p1_gnt} !== {1'b0, exp_v, (n < 4)}) begin
                errors++;
                $display("FAIL lat3 cycle %0d: got rv0=%b rv1=%b gnt1=%b want 0 %b %b", n,
                         s_p0_rvalid, s_p1_rvalid, s_p1_gnt, exp_v, (n < 4));
            end
            if (exp_v) begin
                checks++;
                if (s_p1_rdata !== vals[n-3]) begin
                    errors++;
                    $display("FAIL lat3_data cycle %0d: got %h want %h", n, s_p1_rdata,
                             vals[n-3]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [1:0] g;
        logic       e_we;
        logic [4:0] e_ad;
        logic [31:0] e_din;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            g = m_arb(p0_req, p1_req, m_last);
            checks++;
            if ({p1_gnt, p0_gnt, ram_ce} !== {g, |g}) begin
                errors++;
                $display("FAIL rnd_gnt cycle %0d: got gnt=%b ce=%b want %b %b", i,
                         {p1_gnt, p0_gnt}, ram_ce, g, |g);
            end
            if (g != 2'b00) begin
                e_we  = g[1] ? p1_we : p0_we;
                e_ad  = g[1] ? p1_addr : p0_addr;
                e_din = g[1] ? p1_wdata : p0_wdata;
                checks++;
                if ({ram_wre, ram_ad} !== {e_we, e_ad} || (e_we && ram_din !== e_din)) begin
                    errors++;
                    $display("FAIL rnd_ram cycle %0d: got we=%b ad=%0d din=%h want %b %0d %h",
                             i, ram_wre, ram_ad, ram_din, e_we, e_ad, e_din);
                end
            end
            checks++;
            if ({p1_rvalid, p0_rvalid} !== {m_cur.v && m_cur.id, m_cur.v && !m_cur.id}) begin
                errors++;
                $display("FAIL rnd_rvalid cycle %0d: got %b want v=%b id=%b", i,
                         {p1_rvalid, p0_rvalid}, m_cur.v, m_cur.id);
            end
            if (m_cur.v) begin
                checks++;
                if ((m_cur.id ? p1_rdata : p0_rdata) !== m_cur.d) begin
                    errors++;
                    $display("FAIL rnd_rdata cycle %0d: got %h want %h", i,
                             m_cur.id ? p1_rdata : p0_rdata, m_cur.d);
                end
            end
            tick();
            // A pending request must stay put until granted
            if (!p0_req || g[0]) begin
                p0_req   = ($urandom_range(0, 3) != 0);
                p0_we    = 1'($urandom_range(0, 1));
                p0_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
                p0_wdata = $urandom;
            end
            if (!p1_req || g[1]) begin
                p1_req   = ($urandom_range(0, 3) != 0);
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
                p1_wdata = $urandom;
            end
        end
        p0_req = 0; p1_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single_read();
        test_write_then_read();
        test_collision();
        test_alternate();
        test_reset_midflight();
        test_lat3();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
